// File: rtl/inst_fetch.sv
// Sequential instruction fetch into a DEPTH-entry FIFO toward decode; head valid two cycles after the request edge at best.
// dec_ready stalls pops; no new request issues once buffered plus in-flight words would exceed DEPTH; redirect flushes.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CONE    = CW'(1);
    localparam logic [PW-1:0] PONE    = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q;
    logic [31:0]   buf_inst_q [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign push = (state_q == S_WAIT) && mem_rvalid && !redirect;
    assign pop  = (count_q != '0) && dec_ready && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response landing together with redirect has nothing left to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect)        state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                else if (mem_rvalid) state_d = mem_req ? S_WAIT : S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The returning response frees its slot, so the next request may go out in the same cycle.
    always_comb begin
        mem_req = 1'b0;
        if (!rst && !redirect) begin
            if (state_q == S_IDLE) begin
                mem_req = count_q < DEPTH_C;
            end else if (state_q == S_WAIT && mem_rvalid) begin
                mem_req = (count_q + CONE - CW'(pop)) < DEPTH_C;
            end
        end
    end

    assign mem_addr   = mem_req ? fetch_pc_q : 32'h0;
    assign inst_valid = count_q != '0;
    assign inst       = inst_valid ? buf_inst_q[head_q] : 32'h0;
    assign pc         = inst_valid ? buf_pc_q[head_q]   : 32'h0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            count_d    = '0;
        end else begin
            if (mem_req)          fetch_pc_d = fetch_pc_q + 32'd4;
            if (push && !pop)     count_d    = count_q + CONE;
            else if (pop && !push) count_d   = count_q - CONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & ~32'h3;
            req_addr_q <= 32'h0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (mem_req) req_addr_q <= fetch_pc_q;
            if (redirect) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PONE;
                if (pop)  head_q <= head_q + PONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst_q[tail_q] <= mem_rdata;
            buf_pc_q[tail_q]   <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: two instances (DEPTH=2 at PC 0, DEPTH=4 at PC FFFF_FFF8) fed by a latency-programmable memory.
// Delivered instructions are checked against a sequential-stream model that jumps on redirect and restarts on reset.
module tb_inst_fetch;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, dec_ready, redirect;
    logic [31:0] redirect_pc;
    logic        rst_b, dec_ready_b, redirect_b;
    logic [31:0] redirect_pc_b;

    logic        m_req    [2];
    logic [31:0] m_addr   [2];
    logic        m_rvalid [2];
    logic [31:0] m_rdata  [2];
    logic [31:0] inst_a, pc_a, inst_b, pc_b;
    logic        iv_a, iv_b;

    int          lat  [2];
    int          pend [2];
    logic [31:0] paddr[2];

    int          checks, errors;
    logic [31:0] exp_pc, exp_pc_b;

    inst_fetch #(.RESET_PC(RST_A), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_req(m_req[0]), .mem_addr(m_addr[0]),
        .mem_rvalid(m_rvalid[0]), .mem_rdata(m_rdata[0]),
        .inst(inst_a), .pc(pc_a), .inst_valid(iv_a),
        .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    inst_fetch #(.RESET_PC(RST_B), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .mem_req(m_req[1]), .mem_addr(m_addr[1]),
        .mem_rvalid(m_rvalid[1]), .mem_rdata(m_rdata[1]),
        .inst(inst_b), .pc(pc_b), .inst_valid(iv_b),
        .dec_ready(dec_ready_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'd125;
            32'h4:   return 32'd132;
            32'h8:   return 32'd264;
            default: return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
        endcase
    endfunction

    // Memory: a request seen in a cycle returns lat cycles later; rdata is garbage when not valid.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rvalid[i] = 1'b0;
            m_rdata[i]  = 32'h0;
            pend[i]     = 0;
            lat[i]      = 1;
            paddr[i]    = 32'h0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                m_rvalid[i] = 1'b0;
                m_rdata[i]  = $urandom;
                if (pend[i] > 0) begin
                    pend[i]--;
                    if (pend[i] == 0) begin
                        m_rvalid[i] = 1'b1;
                        m_rdata[i]  = word(paddr[i]);
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_req[i] === 1'b1) begin
                    pend[i]  = lat[i];
                    paddr[i] = m_addr[i];
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (m_req[0] !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", m_req[0]); end
        checks++; if (m_addr[0] !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", m_addr[0]); end
        checks++; if (iv_a !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", iv_a); end
        checks++; if (inst_a !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst_a); end
        checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_a); end
        checks++; if (m_req[1] !== 1'b0 || iv_b !== 1'b0) begin
            errors++; $display("FAIL reset_b req %b valid %b want 0 0", m_req[1], iv_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        rst       = 1'b0;
        dec_ready = 1'b1;
        exp_pc    = RST_A;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (m_req[0] !== 1'b1 || m_addr[0] !== RST_A) begin
                    errors++; $display("FAIL first_req req %b addr %h want 1 %h", m_req[0], m_addr[0], RST_A);
                end
            end
            checks++; if (iv_a !== 1'(c >= 3)) begin
                errors++; $display("FAIL basic_latency cycle %0d valid %b want %b", c, iv_a, c >= 3);
            end
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL basic_stream pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        dec_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++; if (m_req[0] !== 1'b0) begin errors++; $display("FAIL stall_no_req cycle %0d got %b want 0", c, m_req[0]); end
                checks++; if (iv_a !== 1'b1 || pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL stall_head valid %b pc %h want 1 %h", iv_a, pc_a, exp_pc);
                end
            end
            @(posedge clk); #1;
        end
        dec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 2) begin
                checks++; if (iv_a !== 1'b1) begin errors++; $display("FAIL stall_full cycle %0d valid %b want 1", c, iv_a); end
            end
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL stall_stream pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0;
        logic seen  = 1'b0;
        lat[0] = 3;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rdw_pre pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            found = (m_req[0] === 1'b1);
            @(posedge clk); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rdw_find_req timeout got 0 want 1"); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        exp_pc = 32'h0000_0100;
        checks++; if (m_req[0] !== 1'b0) begin errors++; $display("FAIL rdw_req_during got %b want 0", m_req[0]); end
        @(posedge clk); #1;
        redirect = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (m_req[0] === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++; if (m_addr[0] !== 32'h0000_0100) begin
                    errors++; $display("FAIL rdw_next_addr got %h want 00000100", m_addr[0]);
                end
            end
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rdw_stream pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_pc == 32'h0000_0100) begin errors++; $display("FAIL rdw_delivered none want pc 00000100"); end
        lat[0] = 1;
    endtask

    task automatic test_redirect_full();
        logic [31:0] tgt;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rdf_pre pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
        tgt         = $urandom;
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        checks++; if (m_rvalid[0] !== 1'b1 || iv_a !== 1'b1) begin
            errors++; $display("FAIL rdf_setup rvalid %b valid %b want 1 1", m_rvalid[0], iv_a);
        end
        exp_pc = tgt & ~32'h3;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (iv_a !== 1'b0) begin errors++; $display("FAIL rdf_flush valid %b want 0", iv_a); end
        checks++; if (m_req[0] !== 1'b1 || m_addr[0] !== exp_pc) begin
            errors++; $display("FAIL rdf_target req %b addr %h want 1 %h", m_req[0], m_addr[0], exp_pc);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (iv_a !== 1'b0) begin errors++; $display("FAIL rdf_no_push valid %b want 0", iv_a); end
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rdf_stream pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_drain();
        logic found = 1'b0;
        lat[0] = 3;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rsd_pre pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            found = (m_req[0] === 1'b1);
            @(posedge clk); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rsd_find_req timeout got 0 want 1"); end
        redirect    = 1'b1;
        redirect_pc = $urandom;
        @(posedge clk); #1;
        redirect = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m_rvalid[0] !== 1'b1) begin errors++; $display("FAIL rsd_setup rvalid %b want 1", m_rvalid[0]); end
        checks++; if (m_req[0] !== 1'b0 || m_addr[0] !== 32'h0) begin
            errors++; $display("FAIL rsd_mem req %b addr %h want 0 0", m_req[0], m_addr[0]);
        end
        checks++; if (iv_a !== 1'b0 || inst_a !== 32'h0 || pc_a !== 32'h0) begin
            errors++; $display("FAIL rsd_outputs valid %b inst %h pc %h want 0 0 0", iv_a, inst_a, pc_a);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        lat[0] = 1;
        exp_pc = RST_A;
        @(negedge clk);
        checks++; if (m_req[0] !== 1'b1 || m_addr[0] !== RST_A) begin
            errors++; $display("FAIL rsd_restart req %b addr %h want 1 %h", m_req[0], m_addr[0], RST_A);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (iv_a === 1'b1) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rsd_stream pc %h inst %h want %h %h", pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
            end
            @(posedge clk); #1;
        end
        checks++; if (exp_pc == RST_A) begin errors++; $display("FAIL rsd_delivered none want pc %h", RST_A); end
    endtask

    task automatic test_random();
        int delivered = 0;
        for (int c = 0; c < 400; c++) begin
            dec_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            if ($urandom_range(0, 15) == 0) lat[0] = $urandom_range(1, 3);
            @(negedge clk);
            if (m_req[0] === 1'b1) begin
                checks++; if (m_addr[0][1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align addr %h want low bits 0", m_addr[0]); end
            end
            if (redirect) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (iv_a === 1'b1 && dec_ready) begin
                checks++; if (pc_a !== exp_pc || inst_a !== word(exp_pc)) begin
                    errors++; $display("FAIL rnd_stream cycle %0d pc %h inst %h want %h %h", c, pc_a, inst_a, exp_pc, word(exp_pc));
                end
                exp_pc += 32'd4;
                delivered++;
            end
            @(posedge clk); #1;
        end
        redirect  = 1'b0;
        dec_ready = 1'b1;
        lat[0]    = 1;
        checks++; if (delivered < 20) begin errors++; $display("FAIL rnd_progress delivered %0d want >= 20", delivered); end
    endtask

    task automatic test_wrap_b();
        logic [31:0] seq [3];
        int n = 0;
        seq[0] = 32'hFFFF_FFF8;
        seq[1] = 32'hFFFF_FFFC;
        seq[2] = 32'h0000_0000;
        rst_b       = 1'b0;
        dec_ready_b = 1'b1;
        exp_pc_b    = RST_B;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (m_req[1] !== 1'b1 || m_addr[1] !== RST_B) begin
                    errors++; $display("FAIL wrap_first_req req %b addr %h want 1 %h", m_req[1], m_addr[1], RST_B);
                end
            end
            if (iv_b === 1'b1) begin
                if (n < 3) begin
                    checks++; if (pc_b !== seq[n]) begin errors++; $display("FAIL wrap_seq %0d pc %h want %h", n, pc_b, seq[n]); end
                end
                checks++; if (pc_b !== exp_pc_b || inst_b !== word(exp_pc_b)) begin
                    errors++; $display("FAIL wrap_stream pc %h inst %h want %h %h", pc_b, inst_b, exp_pc_b, word(exp_pc_b));
                end
                exp_pc_b += 32'd4;
                n++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n < 4) begin errors++; $display("FAIL wrap_count delivered %0d want >= 4", n); end
    endtask

    task automatic test_stall_b();
        dec_ready_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (m_req[1] !== 1'b0 || iv_b !== 1'b1) begin
            errors++; $display("FAIL stall_b_sat req %b valid %b want 0 1", m_req[1], iv_b);
        end
        @(posedge clk); #1;
        dec_ready_b = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 4) begin
                checks++; if (iv_b !== 1'b1) begin errors++; $display("FAIL stall_b_full cycle %0d valid %b want 1", c, iv_b); end
            end
            if (iv_b === 1'b1) begin
                checks++; if (pc_b !== exp_pc_b || inst_b !== word(exp_pc_b)) begin
                    errors++; $display("FAIL stall_b_stream pc %h inst %h want %h %h", pc_b, inst_b, exp_pc_b, word(exp_pc_b));
                end
                exp_pc_b += 32'd4;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        dec_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        rst_b         = 1'b1;
        dec_ready_b   = 1'b0;
        redirect_b    = 1'b0;
        redirect_pc_b = 32'h0;
        exp_pc        = RST_A;
        exp_pc_b      = RST_B;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_full();
        test_reset_in_drain();
        test_random();
        test_wrap_b();
        test_stall_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
